// File: rtl/game_scan_pkg.sv
// -----------------------------------------------------------------------------
// game_scan_pkg
// Shared types and defaults for the frame scanner slice.
//   scan_state_e  : scanner FSM states (IDLE/FETCH/PLOT/DONE)
//   DEF_COORD_W   : default x/y coordinate width
//   DEF_COLOR_W   : default colour width
//   DEF_BG_COLOR  : default background colour value
// -----------------------------------------------------------------------------
package game_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLOT  = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    localparam int DEF_COORD_W  = 8;
    localparam int DEF_COLOR_W  = 3;
    localparam int DEF_BG_COLOR = 0;

endpackage

// File: rtl/game_frame_scanner_xy_counter.sv
// -----------------------------------------------------------------------------
// scan_xy_counter
// Raster-order x/y counter: x runs 0..X_MAX, then wraps and y steps 0..Y_MAX.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   advance     : step to the next pixel in raster order
//   clear       : return to (0,0); wins over advance
//   x, y        : current coordinate (registered)
//   last        : current coordinate is (X_MAX,Y_MAX)
// -----------------------------------------------------------------------------
module scan_xy_counter
    import game_scan_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int X_MAX   = 159,
    parameter int Y_MAX   = 119
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               advance,
    input  logic               clear,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    logic x_at_max;
    logic y_at_max;

    assign x_at_max = (x_q == COORD_W'(X_MAX));
    assign y_at_max = (y_q == COORD_W'(Y_MAX));

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (x_at_max) begin
                x_d = '0;
                y_d = y_at_max ? '0 : y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = x_at_max && y_at_max;

endmodule

// File: rtl/game_frame_scanner.sv
// -----------------------------------------------------------------------------
// game_frame_scanner
// On each frame trigger, sweeps (x,y) over the screen in raster order. For each
// pixel it waits FETCH_LAT cycles, captures the layer colour (or BG_COLOR when
// the game is not running) and issues one plot strobe to the VGA write port.
// Triggers arriving during a sweep are queued (depth one); a further trigger
// while one is already queued is dropped and reported on frame_overrun.
// Ports:
//   clk, resetn    : clock, asynchronous active-low reset
//   enable         : 1 = advance, 0 = hold all state, suppress strobes
//   frame_start    : single-cycle frame trigger
//   game_running   : 1 = plot pix_color, 0 = plot BG_COLOR
//   pix_color      : layer colour for current x,y (valid FETCH_LAT cycles later)
//   x, y, color    : registered pixel coordinate and colour
//   plot           : write strobe, one per pixel
//   busy           : sweep in progress (FETCH/PLOT/DONE)
//   frame_done     : one-cycle pulse after the last pixel
//   frame_overrun  : one-cycle pulse when a trigger is dropped
// Configuration macro SCAN_BG_SKIP_EN: once a full frame has completed, suppress
// plot for pixels that are BG_COLOR now and were BG_COLOR in the previous frame.
// -----------------------------------------------------------------------------
module game_frame_scanner
    import game_scan_pkg::*;
#(
    parameter int                  COORD_W   = DEF_COORD_W,
    parameter int                  X_MAX     = 159,
    parameter int                  Y_MAX     = 119,
    parameter int                  COLOR_W   = DEF_COLOR_W,
    parameter int                  FETCH_LAT = 1,
    parameter logic [COLOR_W-1:0]  BG_COLOR  = COLOR_W'(DEF_BG_COLOR)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               frame_start,
    input  logic               game_running,
    input  logic [COLOR_W-1:0] pix_color,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COLOR_W-1:0] color,
    output logic               plot,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_overrun
);

    localparam int LAT_W = (FETCH_LAT < 2) ? 1 : $clog2(FETCH_LAT + 1);

    scan_state_e        state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               pending_q, pending_d;

    logic xy_advance;
    logic xy_clear;
    logic xy_last;
    logic plot_raw;

    scan_xy_counter #(
        .COORD_W (COORD_W),
        .X_MAX   (X_MAX),
        .Y_MAX   (Y_MAX)
    ) u_xy (
        .clk     (clk),
        .resetn  (resetn),
        .advance (xy_advance),
        .clear   (xy_clear),
        .x       (x),
        .y       (y),
        .last    (xy_last)
    );

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        color_d       = color_q;
        pending_d     = pending_q;
        xy_advance    = 1'b0;
        xy_clear      = 1'b0;
        plot_raw      = 1'b0;
        frame_done    = 1'b0;
        frame_overrun = 1'b0;

        if (!enable) begin
            // Stalled: only the trigger queue may change, so no trigger is lost.
            if (frame_start) begin
                pending_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_start || pending_q) begin
                        state_d   = FETCH;
                        lat_cnt_d = LAT_W'(FETCH_LAT);
                        pending_d = 1'b0;
                        xy_clear  = 1'b1;
                    end
                end
                FETCH: begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                    if (lat_cnt_q == LAT_W'(1)) begin
                        color_d = game_running ? pix_color : BG_COLOR;
                        state_d = PLOT;
                    end
                end
                PLOT: begin
                    plot_raw = 1'b1;
                    if (xy_last) begin
                        state_d  = DONE;
                        xy_clear = 1'b1;
                    end else begin
                        state_d    = FETCH;
                        lat_cnt_d  = LAT_W'(FETCH_LAT);
                        xy_advance = 1'b1;
                    end
                end
                DONE: begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // Triggers during a sweep (DONE included) queue for the next frame.
            if (busy && frame_start) begin
                if (pending_q) begin
                    frame_overrun = 1'b1;
                end else begin
                    pending_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            color_q   <= BG_COLOR;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            color_q   <= color_d;
            pending_q <= pending_d;
        end
    end

    assign color = color_q;

`ifdef SCAN_BG_SKIP_EN
    localparam int NPIX  = (X_MAX + 1) * (Y_MAX + 1);
    localparam int IDX_W = (NPIX < 2) ? 1 : $clog2(NPIX);

    // dirty_q[i] = 1 when pixel i was plotted with a non-background colour last frame.
    logic [NPIX-1:0]  dirty_q;
    logic             seen_frame_q, seen_frame_d;
    logic [IDX_W-1:0] pix_idx;
    logic             skip;

    assign pix_idx = IDX_W'(int'(y) * (X_MAX + 1) + int'(x));

    always_comb begin
        seen_frame_d = seen_frame_q;
        if (frame_done) begin
            seen_frame_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seen_frame_q <= 1'b0;
        end else begin
            seen_frame_q <= seen_frame_d;
        end
    end

    // NOTE: the map is not reset; it is only consulted after a full frame has rewritten every bit.
    always_ff @(posedge clk) begin
        if (plot_raw) begin
            dirty_q[pix_idx] <= (color_q != BG_COLOR);
        end
    end

    assign skip = seen_frame_q && (color_q == BG_COLOR) && !dirty_q[pix_idx];
    assign plot = plot_raw && !skip;
`else
    assign plot = plot_raw;
`endif

endmodule
